// File: rtl/l2_miss_handler.sv
// L2 miss handler: victim select, optional writeback, line fetch, fill.
// One miss in flight; requests outside IDLE are dropped.
module l2_miss_handler #(
  parameter int TAG_W  = 25,
  parameter int IDX_W  = 5,
  parameter int LINE_W = 32,
  parameter int WAYS   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss_req,
  input  logic [TAG_W+IDX_W-1:0]    miss_addr,
  output logic                      req_ready,
  output logic [IDX_W-1:0]          set_index,
  input  logic [2*WAYS-1:0]         lru_in,
  input  logic [WAYS-1:0]           valid_in,
  input  logic [WAYS-1:0]           dirty_in,
  input  logic [WAYS*TAG_W-1:0]     tag_in,
  output logic [1:0]                victim_way,
  input  logic [LINE_W-1:0]         victim_data,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [TAG_W+IDX_W-1:0]    mem_addr,
  output logic [LINE_W-1:0]         mem_wdata,
  input  logic [LINE_W-1:0]         mem_rdata,
  input  logic                      mem_ack,
  output logic                      fill_we,
  output logic [TAG_W-1:0]          fill_tag,
  output logic [LINE_W-1:0]         fill_data,
  output logic [1:0]                fill_way,
  output logic [2*WAYS-1:0]         new_lru,
  output logic                      done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] WBACK  = 3'd2;
  localparam logic [2:0] FETCH  = 3'd3;
  localparam logic [2:0] FILL   = 3'd4;

  logic [2:0]             state;
  logic [TAG_W+IDX_W-1:0] addr_q;
  logic [TAG_W-1:0]       v_tag;
  logic [1:0]             v_age;
  logic [2*WAYS-1:0]      lru_q;
  logic [LINE_W-1:0]      rdata_q;
  logic [1:0]             sel;
  logic                   sel_dirty;

  // Victim choice: first invalid way, else first way of maximum age
  always_comb begin
    logic found;
    logic [1:0] max_age;
    found   = 1'b0;
    sel     = 2'd0;
    max_age = lru_in[1:0];
    for (int i = 0; i < WAYS; i++) begin
      if (!found && !valid_in[i]) begin
        sel   = 2'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 1; i < WAYS; i++) begin
        if (lru_in[2*i +: 2] > max_age) begin
          max_age = lru_in[2*i +: 2];
          sel     = 2'(i);
        end
      end
    end
    sel_dirty = valid_in[sel] & dirty_in[sel];
  end

  // State register and per-miss captured context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      victim_way <= '0;
      v_tag      <= '0;
      v_age      <= '0;
      lru_q      <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            addr_q <= miss_addr;
            state  <= SELECT;
          end
        end
        SELECT: begin
          victim_way <= sel;
          v_tag      <= tag_in[int'(sel)*TAG_W +: TAG_W];
          v_age      <= lru_in[int'(sel)*2 +: 2];
          lru_q      <= lru_in;
          state      <= sel_dirty ? WBACK : FETCH;
        end
        WBACK: begin
          if (mem_ack) state <= FETCH;
        end
        FETCH: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state   <= FILL;
          end
        end
        FILL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // State-decoded outputs; everything idles at zero
  always_comb begin
    req_ready = 1'b0;
    set_index = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_we   = 1'b0;
    done      = 1'b0;
    fill_tag  = '0;
    fill_data = '0;
    fill_way  = '0;
    new_lru   = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      SELECT: set_index = addr_q[IDX_W-1:0];
      WBACK: begin
        set_index = addr_q[IDX_W-1:0];
        mem_wr    = 1'b1;
        mem_addr  = {v_tag, addr_q[IDX_W-1:0]};
        mem_wdata = victim_data;
      end
      FETCH: begin
        set_index = addr_q[IDX_W-1:0];
        mem_rd    = 1'b1;
        mem_addr  = addr_q;
      end
      FILL: begin
        set_index = addr_q[IDX_W-1:0];
        fill_we   = 1'b1;
        done      = 1'b1;
        fill_way  = victim_way;
        fill_tag  = addr_q[TAG_W+IDX_W-1:IDX_W];
        fill_data = rdata_q;
        for (int i = 0; i < WAYS; i++) begin
          if (2'(i) == victim_way)
            new_lru[2*i +: 2] = 2'd0;
          else if (lru_q[2*i +: 2] < v_age)
            new_lru[2*i +: 2] = lru_q[2*i +: 2] + 2'd1;
          else
            new_lru[2*i +: 2] = lru_q[2*i +: 2];
        end
      end
      default: ;
    endcase
  end

endmodule
